// File: rtl/turn_detector_hyst_pkg.sv
// turn_detector_hyst_pkg: shared encodings for the hysteretic turn-direction detector.
package turn_detector_hyst_pkg;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_STRAIGHT,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    typedef enum logic [1:0] {
        CL_IN,
        CL_MID,
        CL_POS,
        CL_NEG
    } cls_t;

    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_STRAIGHT,
        CAND_LEFT,
        CAND_RIGHT
    } cand_t;

    function automatic state_t cand_state(cand_t c);
        return c == CAND_LEFT ? ST_LEFT : c == CAND_RIGHT ? ST_RIGHT : ST_STRAIGHT;
    endfunction

    function automatic dir_t cand_dir(cand_t c);
        return c == CAND_LEFT ? DIR_LEFT : c == CAND_RIGHT ? DIR_RIGHT : DIR_STRAIGHT;
    endfunction

endpackage

// File: rtl/turn_detector_hyst_if.sv
// turn_detector_hyst_if: wheel-speed sample bus and direction result bundle.
interface turn_detector_hyst_if #(
    parameter int SPEED_W  = 16,
    parameter int AVG_LOG2 = 2
);
    logic                              in_valid;
    logic [SPEED_W-1:0]                wheel_speed_fl;
    logic [SPEED_W-1:0]                wheel_speed_fr;
    logic [SPEED_W-1:0]                wheel_speed_rl;
    logic [SPEED_W-1:0]                wheel_speed_rr;
    logic [1:0]                        direction;
    logic                              dir_valid;
    logic signed [SPEED_W+AVG_LOG2+1:0] speed_diff;

    modport master (
        output in_valid, wheel_speed_fl, wheel_speed_fr, wheel_speed_rl, wheel_speed_rr,
        input  direction, dir_valid, speed_diff
    );

    modport slave (
        input  in_valid, wheel_speed_fl, wheel_speed_fr, wheel_speed_rl, wheel_speed_rr,
        output direction, dir_valid, speed_diff
    );
endinterface

// File: rtl/side_window_avg.sv
// side_window_avg: boxcar window of side sums with a running accumulator and fill flag.
module side_window_avg #(
    parameter int W        = 17,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [W-1:0]          sample,
    output logic [W+AVG_LOG2-1:0] acc_next,
    output logic                  full
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW    = W + AVG_LOG2;

    logic [W-1:0]    buf_q [DEPTH];
    logic [W-1:0]    oldest;
    logic [AW-1:0]   acc;
    logic [PW-1:0]   ptr;
    logic [AVG_LOG2:0] fill;

    // Loop-based mux keeps the index width legal for a single-entry window.
    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++)
            if (PW'(i) == ptr) oldest = buf_q[i];
    end

    assign acc_next = acc + AW'(sample) - AW'(oldest);
    assign full     = fill == (AVG_LOG2+1)'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            ptr  <= '0;
            fill <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else if (valid) begin
            acc  <= acc_next;
            ptr  <= ptr == PW'(DEPTH-1) ? '0 : ptr + 1'b1;
            fill <= full ? fill : fill + 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (PW'(i) == ptr) buf_q[i] <= sample;
        end
    end
endmodule

// File: rtl/turn_detector_hyst.sv
// turn_detector_hyst: windowed left/right speed difference classified with deadband,
// enter/exit hysteresis and a consecutive-sample debounce.
module turn_detector_hyst
    import turn_detector_hyst_pkg::*;
#(
    parameter int SPEED_W  = 16,
    parameter int AVG_LOG2 = 2,
    parameter int DEADBAND = 16,
    parameter int HYST     = 8,
    parameter int HOLD     = 4
) (
    input logic                clk,
    input logic                rst,
    turn_detector_hyst_if.slave bus
);
    localparam int AW = SPEED_W + 1 + AVG_LOG2;
    localparam int DW = AW + 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam logic signed [DW-1:0] ENT_T = DW'((DEADBAND + HYST) << (AVG_LOG2 + 1));
    localparam logic signed [DW-1:0] DB_T  = DW'(DEADBAND << (AVG_LOG2 + 1));

    logic [SPEED_W:0]      sum_l, sum_r;
    logic [AW-1:0]         acc_l, acc_r;
    logic                  full_l, full_r, full;
    logic signed [DW-1:0]  diff;
    cls_t                  cls;
    cand_t                 cand, prev;
    state_t                state;
    dir_t                  dir_q;
    logic [CW-1:0]         cnt, run;
    logic                  done;

    assign sum_l = {1'b0, bus.wheel_speed_fl} + {1'b0, bus.wheel_speed_rl};
    assign sum_r = {1'b0, bus.wheel_speed_fr} + {1'b0, bus.wheel_speed_rr};

    side_window_avg #(.W(SPEED_W + 1), .AVG_LOG2(AVG_LOG2)) u_left (
        .clk(clk), .rst(rst), .valid(bus.in_valid), .sample(sum_l), .acc_next(acc_l), .full(full_l)
    );

    side_window_avg #(.W(SPEED_W + 1), .AVG_LOG2(AVG_LOG2)) u_right (
        .clk(clk), .rst(rst), .valid(bus.in_valid), .sample(sum_r), .acc_next(acc_r), .full(full_r)
    );

    assign full          = full_l & full_r;
    assign diff          = $signed({1'b0, acc_l}) - $signed({1'b0, acc_r});
    assign bus.dir_valid = full;
    assign bus.direction = dir_q;

    // Thresholds are pre-scaled so the window sum compares against per-wheel average speed.
    always_comb begin
        cls  = diff > ENT_T ? CL_POS :
               diff < -ENT_T ? CL_NEG :
               (diff <= DB_T && diff >= -DB_T) ? CL_IN : CL_MID;
        cand = cls == CL_IN  ? (state == ST_STRAIGHT ? CAND_NONE : CAND_STRAIGHT) :
               cls == CL_POS ? (state == ST_RIGHT    ? CAND_NONE : CAND_RIGHT) :
               cls == CL_NEG ? (state == ST_LEFT     ? CAND_NONE : CAND_LEFT) : CAND_NONE;
        run  = cand == prev ? (cnt == CW'(HOLD) ? cnt : cnt + 1'b1) : CW'(1);
        done = cand != CAND_NONE && run == CW'(HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_STRAIGHT;
            dir_q          <= DIR_STRAIGHT;
            prev           <= CAND_NONE;
            cnt            <= '0;
            bus.speed_diff <= '0;
        end else if (bus.in_valid) begin
            bus.speed_diff <= diff;
            if (full) begin
                cnt  <= (cand == CAND_NONE || done) ? '0 : run;
                prev <= done ? CAND_NONE : cand;
                if (done) begin
                    state <= cand_state(cand);
                    dir_q <= cand_dir(cand);
                end
            end
        end
    end
endmodule

// File: tb/tb_turn_detector_hyst.sv
// tb_turn_detector_hyst: table-driven scoreboard bench for two detector configurations
// (4-deep window and unfiltered), plus async reset mid-run sequences.
module tb_turn_detector_hyst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_detector_hyst_if #(.SPEED_W(16), .AVG_LOG2(2)) ia ();
    turn_detector_hyst_if #(.SPEED_W(16), .AVG_LOG2(0)) ib ();

    turn_detector_hyst #(.SPEED_W(16), .AVG_LOG2(2), .DEADBAND(16), .HYST(8), .HOLD(4)) da (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    turn_detector_hyst #(.SPEED_W(16), .AVG_LOG2(0), .DEADBAND(16), .HYST(8), .HOLD(4)) db (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    typedef struct {
        logic [1:0] dir;
        bit         v;
        int         diff;
    } exp_t;

    typedef struct {
        bit         sel;
        int         l;
        int         r;
        logic [1:0] dir;
        bit         v;
        int         diff;
        int         gap;
    } vec_t;

    vec_t tv[$];
    exp_t sb[$];
    exp_t last[2];
    exp_t z;
    int passed = 0;
    int total  = 0;

    function automatic void add(bit sel, int l, int r, logic [1:0] dir, bit v, int diff, int gap = 0);
        vec_t t;
        t = '{sel, l, r, dir, v, diff, gap};
        tv.push_back(t);
    endfunction

    task automatic chk(string n, int got, int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, got, exp);
    endtask

    task automatic put(bit sel, int l, int r, logic v);
        if (sel) begin
            ib.in_valid = v; ib.wheel_speed_fl = 16'(l); ib.wheel_speed_rl = 16'(l);
            ib.wheel_speed_fr = 16'(r); ib.wheel_speed_rr = 16'(r);
        end else begin
            ia.in_valid = v; ia.wheel_speed_fl = 16'(l); ia.wheel_speed_rl = 16'(l);
            ia.wheel_speed_fr = 16'(r); ia.wheel_speed_rr = 16'(r);
        end
    endtask

    task automatic observe(bit sel, string n, exp_t e);
        int gd, gv, gs;
        gd = sel ? int'(ib.direction) : int'(ia.direction);
        gv = sel ? int'(ib.dir_valid) : int'(ia.dir_valid);
        gs = sel ? int'(ib.speed_diff) : int'(ia.speed_diff);
        chk({n, ".direction"}, gd, int'(e.dir));
        chk({n, ".dir_valid"}, gv, int'(e.v));
        chk({n, ".speed_diff"}, gs, e.diff);
    endtask

    task automatic sample(bit sel, int l, int r, logic [1:0] dir, bit v, int diff, string n);
        exp_t e;
        @(negedge clk);
        put(sel, l, r, 1'b1);
        e = '{dir, v, diff};
        sb.push_back(e);
        @(posedge clk);
        #1;
        put(sel, l, r, 1'b0);
        if (sb.size() == 0) chk({n, ".scoreboard_empty"}, 0, 1);
        else begin
            e = sb.pop_front();
            observe(sel, n, e);
            last[sel] = e;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        z = '{2'b00, 1'b0, 0};
        // Config A (window 4): fill, then entry with idle gaps
        for (int k = 0; k < 4; k++) add(0, 1000, 1000, 2'b00, k == 3, 0);
        add(0, 1040, 1000, 2'b00, 1, 80, 2);
        add(0, 1040, 1000, 2'b00, 1, 160);
        add(0, 1040, 1000, 2'b00, 1, 240, 3);
        add(0, 1040, 1000, 2'b00, 1, 320);
        add(0, 1040, 1000, 2'b00, 1, 320, 1);
        add(0, 1040, 1000, 2'b10, 1, 320);
        // Hold d=20 inside the MID band: stays RIGHT
        add(0, 1020, 1000, 2'b10, 1, 280);
        add(0, 1020, 1000, 2'b10, 1, 240);
        add(0, 1020, 1000, 2'b10, 1, 200);
        for (int k = 0; k < 17; k++) add(0, 1020, 1000, 2'b10, 1, 160, k == 8 ? 2 : 0);
        // Exit to straight after 4 IN samples
        add(0, 1000, 1000, 2'b10, 1, 120);
        add(0, 1000, 1000, 2'b10, 1, 80);
        add(0, 1000, 1000, 2'b10, 1, 40);
        add(0, 1000, 1000, 2'b00, 1, 0);
        // Config B (no filtering): fill, chatter, entry, reversal, MID hold, exit
        add(1, 1000, 1000, 2'b00, 1, 0);
        for (int k = 0; k < 12; k++) add(1, k % 2 ? 1010 : 1030, 1000, 2'b00, 1, k % 2 ? 20 : 60);
        for (int k = 0; k < 4; k++) add(1, 1030, 1000, k == 3 ? 2'b10 : 2'b00, 1, 60);
        for (int k = 0; k < 4; k++) add(1, 1000, 1030, k == 3 ? 2'b01 : 2'b10, 1, -60);
        for (int k = 0; k < 3; k++) add(1, 1000, 1020, 2'b01, 1, -40);
        for (int k = 0; k < 4; k++) add(1, 1000, 1000, k == 3 ? 2'b00 : 2'b01, 1, 0);

        put(0, 0, 0, 1'b0);
        put(1, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        observe(0, "reset_a", z);
        observe(1, "reset_b", z);
        last[0] = z;
        last[1] = z;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].gap > 0) begin
                repeat (tv[i].gap) @(negedge clk);
                observe(tv[i].sel, $sformatf("gap%0d", i), last[tv[i].sel]);
            end
            sample(tv[i].sel, tv[i].l, tv[i].r, tv[i].dir, tv[i].v, tv[i].diff, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a debounce run: 3 of 4 POS samples
        sample(0, 1100, 1000, 2'b00, 1, 200, "pre_rst0");
        sample(0, 1100, 1000, 2'b00, 1, 400, "pre_rst1");
        sample(0, 1100, 1000, 2'b00, 1, 600, "pre_rst2");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        observe(0, "async_rst_a", z);
        observe(1, "async_rst_b", z);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++)
            sample(0, 1000, 1000, 2'b00, k == 3, 0, $sformatf("refill%0d", k));
        // Debounce must restart from zero after reset
        sample(0, 1100, 1000, 2'b00, 1, 200, "post_rst0");
        sample(0, 1100, 1000, 2'b00, 1, 400, "post_rst1");
        sample(0, 1100, 1000, 2'b00, 1, 600, "post_rst2");
        sample(0, 1100, 1000, 2'b10, 1, 800, "post_rst3");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
